// File: rtl/mem_stage_if.sv
// Bundle of the execute-side, data-memory and writeback signals of the memory stage.
// The slave modport is the stage itself; the master modport is its environment.
interface mem_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        branch_taken;
    logic        err;

    modport slave (
        input  in_valid, in_op, alu_result, alu_zero, store_data, dest_reg,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output wb_valid, wb_we, wb_reg, wb_data, branch_taken, err
    );

    modport master (
        output in_valid, in_op, alu_result, alu_zero, store_data, dest_reg,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  wb_valid, wb_we, wb_reg, wb_data, branch_taken, err
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of a multi-cycle MIPS-like core: performs lw/sw through a req/ack port
// with a bounded wait, and retires ALU, branch and memory results one at a time.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RETIRE} state_e;
    typedef enum logic [1:0] {K_ALU, K_BEQ, K_LW, K_SW} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q, kind_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [4:0]        dest_q, dest_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              accept;
    logic              retire;

    function automatic kind_e decode(input logic [5:0] op);
        case (op)
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            OP_BEQ:  return K_BEQ;
            default: return K_ALU;
        endcase
    endfunction

    function automatic logic misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

    assign accept = bus.in_valid && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        dest_d   = dest_q;
        zero_d   = zero_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    kind_d   = decode(bus.in_op);
                    result_d = bus.alu_result;
                    wdata_d  = bus.store_data;
                    dest_d   = bus.dest_reg;
                    zero_d   = bus.alu_zero;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    if (kind_d == K_LW || kind_d == K_SW) begin
                        // A misaligned address never reaches the memory port.
                        if (misaligned(bus.alu_result)) begin
                            err_d   = 1'b1;
                            state_d = RETIRE;
                        end else begin
                            state_d = ACCESS;
                        end
                    end else begin
                        state_d = RETIRE;
                    end
                end
            end
            ACCESS: begin
                // Ack is checked before the timeout so a last-cycle ack still completes.
                if (bus.mem_ack) begin
                    if (kind_q == K_LW) begin
                        rdata_d = bus.mem_rdata;
                    end
                    state_d = RETIRE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RETIRE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            kind_q   <= K_ALU;
            cnt_q    <= '0;
            result_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dest_q   <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            dest_q   <= dest_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign retire = (state_q == RETIRE);

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.mem_req   = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && (kind_q == K_SW);
    assign bus.mem_addr  = result_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.wb_valid     = retire;
    assign bus.wb_reg       = dest_q;
    assign bus.wb_data      = (kind_q == K_LW) ? rdata_q : result_q;
    assign bus.wb_we        = retire && !err_q && (dest_q != 5'd0) &&
                              (kind_q == K_ALU || kind_q == K_LW);
    assign bus.branch_taken = retire && (kind_q == K_BEQ) && zero_q;
    assign bus.err          = retire && err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected retirements are queued at issue time and a
// negedge monitor checks every retirement, memory-port cycle and idle-output condition.
module tb_mem_stage;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_ADD = 6'b000000;

    typedef struct {
        int          lat;
        int          reqs;
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        chk_data;
        logic        bt;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          acc_cyc = 0;
    int          req_cnt = 0;
    logic        chk_rdy = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic        exp_we    = 1'b0;
    logic [31:0] exp_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pops on retire, plus memory-port and idle-output checks.
    always @(negedge clk) begin
        if (chk_rdy) begin
            chk("ready_after_retire", 32'(bus.in_ready), 32'd1);
            chk_rdy = 1'b0;
        end
        if (bus.in_valid && bus.in_ready && !rst) acc_cyc = cyc;
        if (bus.mem_req) begin
            req_cnt++;
            chk("mem_addr", bus.mem_addr, exp_addr);
            chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
            if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
        end
        if (rst) req_cnt = 0;
        if (bus.wb_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", 32'(bus.wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                chk("mem_req_cycles", 32'(req_cnt), 32'(e.reqs));
                chk("wb_we", 32'(bus.wb_we), 32'(e.we));
                chk("branch_taken", 32'(bus.branch_taken), 32'(e.bt));
                chk("err", 32'(bus.err), 32'(e.err));
                if (e.chk_data) begin
                    chk("wb_reg", 32'(bus.wb_reg), 32'(e.rg));
                    chk("wb_data", bus.wb_data, e.data);
                end
            end
            req_cnt = 0;
            chk_rdy = 1'b1;
        end else if (!rst) begin
            chk("idle_flags", {29'd0, bus.wb_we, bus.branch_taken, bus.err}, 32'd0);
        end
    end

    task automatic push(input int lat, input int reqs, input logic we, input logic [4:0] rg,
                        input logic [31:0] data, input logic cd, input logic bt, input logic er);
        exp_t e;
        e.lat = lat; e.reqs = reqs; e.we = we; e.rg = rg;
        e.data = data; e.chk_data = cd; e.bt = bt; e.err = er;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic zero,
                         input logic [31:0] sd, input logic [4:0] dr);
        int w;
        w = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) chk("ready_wait", 32'd0, 32'd1);
        exp_addr  = res;
        exp_we    = (op == OP_SW);
        exp_wdata = sd;
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.alu_result = res;
        bus.alu_zero   = zero;
        bus.store_data = sd;
        bus.dest_reg   = dr;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.in_op      = 6'h3F;
        bus.alu_result = 32'hFFFF_FFFF;
        bus.store_data = 32'h5555_5555;
        bus.dest_reg   = 5'd31;
    endtask

    // Raises mem_ack in the n-th ACCESS cycle (called right after the accept edge).
    task automatic ack_in(input int n, input logic [31:0] data);
        for (int k = 1; k <= n; k++) begin
            if (k == n) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = data;
            end
            @(posedge clk); #1;
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0BAD_0BAD;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = 6'd0; bus.alu_result = '0; bus.alu_zero = 1'b0;
        bus.store_data = '0; bus.dest_reg = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_wb_flags", {28'd0, bus.wb_valid, bus.wb_we, bus.branch_taken, bus.err}, 32'd0);
        chk("rst_wb_reg", 32'(bus.wb_reg), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        rst = 1'b0;

        // ALU writeback, then ALU to r0 (write suppressed)
        push(1, 0, 1'b1, 5'd3, 32'h0000_0005, 1'b1, 1'b0, 1'b0);
        issue(OP_ADD, 32'h0000_0005, 1'b0, 32'h0, 5'd3);
        push(1, 0, 1'b0, 5'd0, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
        issue(6'b001000, 32'h0000_1234, 1'b1, 32'h0, 5'd0);

        // lw 0x10, ack in the 3rd access cycle
        push(4, 3, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        issue(OP_LW, 32'h0000_0010, 1'b0, 32'h0, 5'd7);
        ack_in(3, 32'hDEAD_BEEF);

        // aligned sw, immediate ack
        push(2, 1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_SW, 32'h0000_0040, 1'b0, 32'hCAFE_F00D, 5'd9);
        ack_in(1, 32'h1111_1111);

        // misaligned sw and lw
        push(1, 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(OP_SW, 32'h0000_0013, 1'b0, 32'h1234_5678, 5'd4);
        push(1, 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(OP_LW, 32'h0000_0022, 1'b0, 32'h0, 5'd5);

        // beq taken / not taken
        push(1, 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(OP_BEQ, 32'h0, 1'b1, 32'h0, 5'd0);
        push(1, 0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(OP_BEQ, 32'h0000_0008, 1'b0, 32'h0, 5'd0);

        // lw timeout with no ack
        push(17, 16, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(OP_LW, 32'h0000_0100, 1'b0, 32'h0, 5'd6);
        repeat (18) @(posedge clk);
        #1;

        // ack on the very cycle the wait would expire completes normally
        push(17, 16, 1'b1, 5'd8, 32'h0F0F_A5A5, 1'b1, 1'b0, 1'b0);
        issue(OP_LW, 32'h0000_0104, 1'b0, 32'h0, 5'd8);
        ack_in(16, 32'h0F0F_A5A5);

        // lw to r0: data returned, write suppressed
        push(2, 1, 1'b0, 5'd0, 32'h7777_0001, 1'b1, 1'b0, 1'b0);
        issue(OP_LW, 32'h0000_0200, 1'b0, 32'h0, 5'd0);
        ack_in(1, 32'h7777_0001);

        // stray ack while idle has no effect on the next ALU op
        @(posedge clk); #1;
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        push(1, 0, 1'b1, 5'd2, 32'h0000_00AA, 1'b1, 1'b0, 1'b0);
        issue(OP_ADD, 32'h0000_00AA, 1'b0, 32'h0, 5'd2);

        // reset in the 2nd access cycle, ack one cycle later
        issue(OP_LW, 32'h0000_0020, 1'b0, 32'h0, 5'd10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1357_9BDF;
        chk("rst_access_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_access_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_access_wb_valid", 32'(bus.wb_valid), 32'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
        chk("late_ack_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("late_ack_in_ready", 32'(bus.in_ready), 32'd1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
